// File: rtl/echo_pkg.sv
// Shared types and default sizing for the echo range binner.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    FLUSH
  } state_t;

  localparam int NBINS_DEF = 32;
  localparam int HIT_W_DEF = 4;
  localparam int NO_ECHO   = NBINS_DEF;

endpackage

// File: rtl/echo_line_ram.sv
// Ping-pong line store: two banks of hit counts, one write port and one
// registered read port. Only the read register is reset, never the array.
module echo_line_ram #(
  parameter  int NBINS = 32,
  parameter  int HIT_W = 4,
  localparam int AW    = $clog2(NBINS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [HIT_W-1:0] wr_data_i,
  input  logic             rd_bank_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [HIT_W-1:0] rd_data_o
);

  logic [HIT_W-1:0] mem_q [2**(AW+1)];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

endmodule

// File: rtl/echo_binner.sv
// Echo range binner: counts synchronized echo hits per 1-cm bin into a
// ping-pong line store. Near-field blanking is compiled in with ECHO_BLANKING_EN.
module echo_binner
  import echo_pkg::*;
#(
  parameter  int NBINS      = NBINS_DEF,
  parameter  int HIT_W      = HIT_W_DEF,
  parameter  int THRESH     = 2,
  parameter  int BLANK_BINS = 3,
  localparam int AW         = $clog2(NBINS)
) (
  input  logic             clk_5M,
  input  logic             reset_in,
  input  logic             receive,
  input  logic             markers,
  input  logic             echo_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [HIT_W-1:0] rd_data,
  output logic             line_done,
  output logic             line_valid,
  output logic [AW:0]      first_range,
  output logic             overflow
);

`ifdef ECHO_BLANKING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [AW:0]      BIN_END = (AW+1)'(NBINS);
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  state_t           state_q, state_d;
  logic             echo_meta_q, echo_sync_q, recv_prev_q;
  logic             bank_q, bank_d;
  logic [AW:0]      bin_q, bin_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic [AW:0]      first_q, first_d;
  logic             ovf_line_q, ovf_line_d;
  logic             line_done_q, line_done_d;
  logic             line_valid_q, line_valid_d;
  logic [AW:0]      first_range_q, first_range_d;
  logic             overflow_q, overflow_d;

  logic             bin_open, echo_hit, wr_en;
  logic [HIT_W-1:0] hit_inc, wr_data;

  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    bin_d         = bin_q;
    hit_d         = hit_q;
    first_d       = first_q;
    ovf_line_d    = ovf_line_q;
    line_done_d   = 1'b0;
    line_valid_d  = line_valid_q;
    first_range_d = first_range_q;
    overflow_d    = overflow_q;
    wr_en         = 1'b0;

    bin_open = (bin_q < BIN_END);
    echo_hit = echo_sync_q && !(BLANK_EN && (int'(bin_q) < BLANK_BINS));
    hit_inc  = (echo_hit && (hit_q != HIT_MAX)) ? hit_q + 1'b1 : hit_q;
    wr_data  = hit_inc;

    case (state_q)
      IDLE: begin
        if (receive && !recv_prev_q) begin
          state_d    = ACQUIRE;
          bin_d      = '0;
          hit_d      = '0;
          first_d    = BIN_END;
          ovf_line_d = 1'b0;
        end
      end
      ACQUIRE: begin
        hit_d = hit_inc;
        // A falling receive takes priority over a marker in the same cycle.
        if (!receive) begin
          state_d = FLUSH;
          hit_d   = '0;
          if (bin_open) begin
            wr_en = 1'b1;
            bin_d = bin_q + 1'b1;
          end
        end else if (markers) begin
          hit_d = '0;
          if (bin_open) begin
            wr_en = 1'b1;
            bin_d = bin_q + 1'b1;
          end else begin
            ovf_line_d = 1'b1;
          end
        end
        if (wr_en && (first_q == BIN_END) && (int'(hit_inc) >= THRESH)) begin
          first_d = bin_q;
        end
      end
      FLUSH: begin
        if (bin_open) begin
          wr_en   = 1'b1;
          wr_data = '0;
          bin_d   = bin_q + 1'b1;
        end else begin
          state_d       = IDLE;
          bank_d        = !bank_q;
          line_done_d   = 1'b1;
          line_valid_d  = 1'b1;
          first_range_d = first_q;
          overflow_d    = ovf_line_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_5M) begin
    if (!reset_in) begin
      state_q       <= IDLE;
      echo_meta_q   <= 1'b0;
      echo_sync_q   <= 1'b0;
      recv_prev_q   <= 1'b0;
      bank_q        <= 1'b0;
      bin_q         <= '0;
      hit_q         <= '0;
      first_q       <= BIN_END;
      ovf_line_q    <= 1'b0;
      line_done_q   <= 1'b0;
      line_valid_q  <= 1'b0;
      first_range_q <= BIN_END;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      echo_meta_q   <= echo_in;
      echo_sync_q   <= echo_meta_q;
      recv_prev_q   <= receive;
      bank_q        <= bank_d;
      bin_q         <= bin_d;
      hit_q         <= hit_d;
      first_q       <= first_d;
      ovf_line_q    <= ovf_line_d;
      line_done_q   <= line_done_d;
      line_valid_q  <= line_valid_d;
      first_range_q <= first_range_d;
      overflow_q    <= overflow_d;
    end
  end

  // The write bank is bank_q; the display always reads the other one.
  echo_line_ram #(
    .NBINS (NBINS),
    .HIT_W (HIT_W)
  ) u_ram (
    .clk_i     (clk_5M),
    .rst_ni    (reset_in),
    .wr_en_i   (wr_en),
    .wr_bank_i (bank_q),
    .wr_addr_i (bin_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_bank_i (!bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign line_done   = line_done_q;
  assign line_valid  = line_valid_q;
  assign first_range = first_range_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_echo_binner.sv
// Scoreboard bench for echo_binner: stimulus queues expected line results and
// bin read-backs; a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_echo_binner;
  import echo_pkg::*;

  localparam int NB      = NBINS_DEF;
  localparam int HW      = HIT_W_DEF;
  localparam int AW      = $clog2(NB);
  localparam int TH      = 2;
  localparam int BLANK_N = 3;
  localparam int HMAX    = (1 << HW) - 1;
`ifdef ECHO_BLANKING_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic          clk_5M = 1'b0;
  logic          reset_in, receive, markers, echo_in;
  logic [AW-1:0] rd_addr;
  logic [HW-1:0] rd_data;
  logic          line_done, line_valid, overflow;
  logic [AW:0]   first_range;

  logic rd_req = 1'b0;
  logic rd_chk = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int lines   = 0;

  int lq_first[$];
  int lq_ovf[$];
  int rq_bin[$];
  int rq_data[$];

  always #100 clk_5M = ~clk_5M;

  echo_binner #(
    .NBINS      (NB),
    .HIT_W      (HW),
    .THRESH     (TH),
    .BLANK_BINS (BLANK_N)
  ) dut (
    .clk_5M      (clk_5M),
    .reset_in    (reset_in),
    .receive     (receive),
    .markers     (markers),
    .echo_in     (echo_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .line_done   (line_done),
    .line_valid  (line_valid),
    .first_range (first_range),
    .overflow    (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int hv(input int b, input int n);
    if (BLANK_ON && b < BLANK_N) return 0;
    return (n > HMAX) ? HMAX : n;
  endfunction

  function automatic int ef(input int b, input int n);
    return (hv(b, n) >= TH) ? b : NO_ECHO;
  endfunction

  // Edges from the falling-receive sample up to and including the swap.
  function automatic int fl(input int nmk);
    return (nmk < NB) ? (NB - nmk + 1) : 2;
  endfunction

  always @(posedge clk_5M) rd_chk <= rd_req;

  always @(negedge clk_5M) begin
    int e, b;
    if (rd_chk) begin
      if (rq_data.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        e = rq_data.pop_front();
        b = rq_bin.pop_front();
        $display("read  bin %0d: data %0d (exp %0d)", b, rd_data, e);
        check($sformatf("rd_bin%0d", b), int'(rd_data), e);
      end
    end
    if (line_done === 1'b1) begin
      if (lq_first.size() == 0) begin
        check("line_done_unexpected", int'(line_done), 0);
      end else begin
        lines++;
        e = lq_first.pop_front();
        b = lq_ovf.pop_front();
        $display("line  %0d done: first_range %0d (exp %0d) overflow %0d (exp %0d)",
                 lines, first_range, e, overflow, b);
        check("first_range", int'(first_range), e);
        check("overflow", int'(overflow), b);
        check("line_valid", int'(line_valid), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_5M);
    #1;
  endtask

  // Echo of elen cycles placed in bin ebin (ebin == nmk: after the last marker).
  task automatic window(input int nmk, input int ebin, input int elen);
    receive = 1'b1;
    tick();
    for (int b = 0; b <= nmk; b++) begin
      if (b == ebin) begin
        echo_in = 1'b1;
        repeat (elen) tick();
        echo_in = 1'b0;
      end
      repeat (3) tick();
      if (b < nmk) begin
        markers = 1'b1;
        tick();
        markers = 1'b0;
      end
    end
  endtask

  task automatic finish_line(input int exp_first, input int exp_ovf,
                             input int exp_flush, input int bounce);
    int n;
    n = 0;
    lq_first.push_back(exp_first);
    lq_ovf.push_back(exp_ovf);
    receive = 1'b0;
    while (line_done !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == bounce) receive = 1'b1;
    end
    check("line_done_seen", int'(line_done), 1);
    check("flush_edges", n, exp_flush);
    tick();
  endtask

  task automatic read_line(input int eb, input int ev);
    for (int b = 0; b < NB; b++) begin
      rd_addr = AW'(b);
      rd_req  = 1'b1;
      rq_bin.push_back(b);
      rq_data.push_back((b == eb) ? ev : 0);
      tick();
    end
    rd_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #(200 * 20000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0;
    receive  = 1'b0;
    markers  = 1'b0;
    echo_in  = 1'b0;
    rd_addr  = '0;
    repeat (3) tick();
    check("rst_line_done", int'(line_done), 0);
    check("rst_line_valid", int'(line_valid), 0);
    check("rst_first_range", int'(first_range), NO_ECHO);
    check("rst_overflow", int'(overflow), 0);
    check("rst_rd_data", int'(rd_data), 0);
    reset_in = 1'b1;
    tick();

    // 10 echo cycles in bin 5 of a full 32-marker window
    window(32, 5, 10);
    finish_line(ef(5, 10), 0, fl(32), 0);
    read_line(5, hv(5, 10));

    // 40 echo cycles in bin 2 saturate the counter
    window(32, 2, 40);
    finish_line(ef(2, 40), 0, fl(32), 0);
    read_line(2, hv(2, 40));

    // receive falls after 12 markers with 3 hits pending in bin 12
    window(12, 12, 3);
    finish_line(ef(12, 3), 0, fl(12), 0);
    read_line(12, hv(12, 3));

    // 40 markers: extras dropped, overflow flagged
    window(40, -1, 0);
    finish_line(NO_ECHO, 1, fl(40), 0);
    read_line(-1, 0);

    // single hit in bin 1 is below threshold; overflow clears
    window(32, 1, 1);
    finish_line(ef(1, 1), 0, fl(32), 0);
    read_line(1, hv(1, 1));

    // 5 hits in bin 1 (zeroed when blanking is compiled in)
    window(32, 1, 5);
    finish_line(ef(1, 5), 0, fl(32), 0);
    read_line(1, hv(1, 5));

    // receive rises during FLUSH; then idle markers/echoes must do nothing
    window(4, 3, 6);
    finish_line(ef(3, 6), 0, fl(4), 3);
    repeat (5) begin
      markers = 1'b1;
      echo_in = 1'b1;
      tick();
      markers = 1'b0;
      tick();
    end
    echo_in = 1'b0;
    receive = 1'b0;
    repeat (20) tick();
    read_line(3, hv(3, 6));

    // one-cycle reset mid-ACQUIRE abandons the line
    receive = 1'b1;
    tick();
    echo_in = 1'b1;
    repeat (6) tick();
    markers = 1'b1;
    tick();
    markers = 1'b0;
    echo_in = 1'b0;
    repeat (3) tick();
    reset_in = 1'b0;
    receive  = 1'b0;
    tick();
    reset_in = 1'b1;
    check("midrst_line_done", int'(line_done), 0);
    check("midrst_line_valid", int'(line_valid), 0);
    check("midrst_first_range", int'(first_range), NO_ECHO);
    check("midrst_overflow", int'(overflow), 0);
    repeat (40) tick();

    // next full window after reset, exactly THRESH hits in bin 7
    window(32, 7, 2);
    finish_line(ef(7, 2), 0, fl(32), 0);
    read_line(7, hv(7, 2));

    repeat (5) tick();
    check("lines_pending", lq_first.size(), 0);
    check("reads_pending", rq_data.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
